// File: rtl/plot_queue.sv
// Pixel sink for the drawers: buffers plot requests in a small FIFO, clips
// off-screen pixels, and can run a full-screen clear sweep on request.
`timescale 1ns/1ps
module plot_queue #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        clear_req,
  input  logic [2:0]  clear_colour,
  output logic        clear_busy,
  output logic        plot,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  plot_colour,
  output logic        idle,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [8:0]  X_LIM    = 9'(SCREEN_W);
  localparam logic [7:0]  Y_LIM    = 8'(SCREEN_H);
  localparam logic [7:0]  X_LAST   = 8'(SCREEN_W - 1);
  localparam logic [6:0]  Y_LAST   = 7'(SCREEN_H - 1);

  typedef enum logic [0:0] {RUN, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [17:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            clear_pending;
  logic [2:0]      clr_colour;
  logic [7:0]      cx, next_x;
  logic [6:0]      cy, next_y;

  logic full, empty, clipped, accept, push, pop;
  logic clear_accept, start_clear, sweep_last;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign clipped      = ({1'b0, in_x} >= X_LIM) | ({1'b0, in_y} >= Y_LIM);
  assign in_ready     = ~reset & ~full & (state_q == RUN) & ~clear_pending;
  assign accept       = in_valid & in_ready;
  assign push         = accept & ~clipped;
  assign pop          = (state_q == RUN) & ~empty;
  assign clear_accept = clear_req & ~reset & (state_q == RUN) & ~clear_pending;
  assign start_clear  = (state_q == RUN) & clear_pending & empty;
  assign sweep_last   = (state_q == CLEAR) & (cx == X_LAST) & (cy == Y_LAST);
  assign clear_busy   = clear_pending | (state_q == CLEAR);
  assign idle         = empty & ~clear_busy & ~plot;

  always_comb begin
    next_x = cx + 8'd1;
    next_y = cy;
    if (cx == X_LAST) begin
      next_x = '0;
      next_y = cy + 7'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (start_clear) state_d = CLEAR;
      CLEAR:   if (sweep_last)  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_x, in_y, in_colour};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Clear control; cx/cy track the pixel currently on the plot outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_pending <= 1'b0;
      cx            <= '0;
      cy            <= '0;
    end else begin
      if (clear_accept) clear_pending <= 1'b1;
      if (sweep_last)   clear_pending <= 1'b0;
      if (start_clear) begin
        cx <= '0;
        cy <= '0;
      end else if ((state_q == CLEAR) && !sweep_last) begin
        cx <= next_x;
        cy <= next_y;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear_accept) clr_colour <= clear_colour;
  end

  always_ff @(posedge clock) begin
    if (reset) drop_count <= '0;
    else if (accept && clipped) drop_count <= sat_inc(drop_count);
  end

  // Output register stage: one plot strobe per cycle from FIFO or sweep
  always_ff @(posedge clock) begin
    if (reset) begin
      plot        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
    end else if (start_clear) begin
      plot        <= 1'b1;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= clr_colour;
    end else if ((state_q == CLEAR) && !sweep_last) begin
      plot        <= 1'b1;
      plot_x      <= next_x;
      plot_y      <= next_y;
      plot_colour <= clr_colour;
    end else if (pop) begin
      plot                            <= 1'b1;
      {plot_x, plot_y, plot_colour}   <= mem[rd_ptr];
    end else begin
      plot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_plot_queue.sv
// Scoreboard bench for plot_queue: stimulus queues expected plots, a monitor
// pops and compares whenever the DUT strobes plot.
`timescale 1ns/1ps
module tb_plot_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        clear_busy;
  logic        plot;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        idle;
  logic [15:0] drop_count;

  int n_checks  = 0;
  int n_fail    = 0;
  int plot_seen = 0;
  logic [17:0] sb [$];

  always #5 clock = ~clock;

  plot_queue dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .clear_req(clear_req),
    .clear_colour(clear_colour), .clear_busy(clear_busy), .plot(plot),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .idle(idle),
    .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                         input logic exp_ready, input string name);
    in_valid  = 1'b1;
    in_x      = x;
    in_y      = y;
    in_colour = c;
    check(name, 32'(in_ready), 32'(exp_ready));
    if (exp_ready && !(x >= 8'd160 || y >= 7'd120)) sb.push_back({x, y, c});
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_clear_expect(input logic [2:0] c);
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        sb.push_back({8'(xx), 7'(yy), c});
  endtask

  task automatic wait_plots(input int target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (plot_seen >= target) break;
      step();
    end
    check(name, 32'(plot_seen >= target), 32'd1);
  endtask

  always @(negedge clock) begin : monitor
    logic [17:0] e;
    if (plot === 1'b1) begin
      plot_seen++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got (%0d,%0d,%0d), required no plot",
                 plot_x, plot_y, plot_colour);
      end else begin
        e = sb.pop_front();
        if ({plot_x, plot_y, plot_colour} !== e) begin
          n_fail++;
          $display("FAIL plot_data: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                   plot_x, plot_y, plot_colour, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int base;
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    clear_req = 1'b0; clear_colour = '0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_xyc", 32'({plot_x, plot_y, plot_colour}), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);

    // single pixel, 2-edge latency
    push_px(8'd10, 7'd20, 3'd7, 1'b1, "t1_ready");
    check("t1_plot_early", 32'(plot), 32'd0);
    step();
    check("t1_plot", 32'(plot), 32'd1);
    check("t1_xyc", 32'({plot_x, plot_y, plot_colour}), 32'({8'd10, 7'd20, 3'd7}));
    step();
    check("t1_plot_off", 32'(plot), 32'd0);
    check("t1_idle", 32'(idle), 32'd1);

    // 20-pixel stream at one per clock
    base = plot_seen;
    for (int i = 0; i < 20; i++) push_px(8'(i), 7'd5, 3'(i % 8), 1'b1, "t2_ready");
    step();
    check("t2_last_plot", 32'(plot), 32'd1);
    step();
    check("t2_count", 32'(plot_seen - base), 32'd20);
    check("t2_plot_off", 32'(plot), 32'd0);

    // 8 pixels, clear requested with the 8th, 9th refused, then full sweep
    base = plot_seen;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        clear_req = 1'b1;
        clear_colour = 3'b101;
      end
      push_px(8'(20 + i), 7'd30, 3'(i), 1'b1, "t3_ready");
    end
    clear_req = 1'b0;
    push_clear_expect(3'b101);
    check("t3_busy", 32'(clear_busy), 32'd1);
    push_px(8'd100, 7'd100, 3'd1, 1'b0, "t3_refused");
    wait_plots(base + 8 + 19200, 19400, "t3_wait");
    check("t3_count", 32'(plot_seen - base), 32'd19208);
    check("t3_busy_fall", 32'(clear_busy), 32'd0);
    check("t3_plot_off", 32'(plot), 32'd0);
    check("t3_idle", 32'(idle), 32'd1);

    // clipping
    base = plot_seen;
    push_px(8'hFF, 7'h7F, 3'd1, 1'b1, "t4_ready");
    push_px(8'd160, 7'd0, 3'd2, 1'b1, "t4_ready");
    push_px(8'd0, 7'd120, 3'd3, 1'b1, "t4_ready");
    push_px(8'd159, 7'd119, 3'd4, 1'b1, "t4_ready");
    check("t4_drop", 32'(drop_count), 32'd3);
    step(); step();
    check("t4_count", 32'(plot_seen - base), 32'd1);
    check("t4_idle", 32'(idle), 32'd1);

    // drop counter saturation
    for (int i = 0; i < 65531; i++) push_px(8'd200, 7'd0, 3'd0, 1'b1, "t6_ready");
    check("t6_drop_fffe", 32'(drop_count), 32'h0000FFFE);
    push_px(8'd200, 7'd0, 3'd0, 1'b1, "t6_ready");
    check("t6_drop_ffff", 32'(drop_count), 32'h0000FFFF);
    push_px(8'd200, 7'd0, 3'd0, 1'b1, "t6_ready");
    push_px(8'd0, 7'd121, 3'd0, 1'b1, "t6_ready");
    check("t6_drop_hold", 32'(drop_count), 32'h0000FFFF);

    // reset during clear pixel 5000
    base = plot_seen;
    clear_req = 1'b1;
    clear_colour = 3'b010;
    push_clear_expect(3'b010);
    step();
    clear_req = 1'b0;
    wait_plots(base + 4999, 6000, "t5_wait");
    reset = 1'b1;
    step();
    check("t5_plot", 32'(plot), 32'd0);
    check("t5_busy", 32'(clear_busy), 32'd0);
    check("t5_idle", 32'(idle), 32'd1);
    check("t5_xyc", 32'({plot_x, plot_y, plot_colour}), 32'd0);
    check("t5_drop", 32'(drop_count), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_seen", 32'(plot_seen - base), 32'd5000);
    sb.delete();
    reset = 1'b0;
    #1;
    push_px(8'd3, 7'd4, 3'd5, 1'b1, "t5_ready");
    check("t5_plot_early", 32'(plot), 32'd0);
    step();
    check("t5_plot_px", 32'(plot), 32'd1);
    check("t5_xyc_px", 32'({plot_x, plot_y, plot_colour}), 32'({8'd3, 7'd4, 3'd5}));
    step();
    check("t5_plot_off", 32'(plot), 32'd0);
    check("t5_idle_end", 32'(idle), 32'd1);

    step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
